// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared types for the writeback merge unit: load-format encoding,
//            buffered result entry and the load-data formatting function.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Load-data formatting selector carried with every result
    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5,
        LD_LWU  = 3'd6,
        LD_LD   = 3'd7
    } ld_fmt_e;

    // One buffered result; data is held at the widest supported XLEN
    typedef struct packed {
        logic [4:0]  rd;
        logic        fpr;
        ld_fmt_e     fmt;
        logic [63:0] data;
    } wb_entry_t;

    // Sign/zero extension of load data. LWU and LD have no meaning on a
    // 32-bit datapath and fall back to pass-through.
    function automatic logic [63:0] ld_format(input ld_fmt_e fmt,
                                              input logic [63:0] data,
                                              input logic is_64);
        logic [63:0] res;
        ld_fmt_e     f;
        f = fmt;
        if (!is_64 && ((fmt == LD_LWU) || (fmt == LD_LD))) begin
            f = LD_NONE;
        end
        case (f)
            LD_LB:   res = {{56{data[7]}},  data[7:0]};
            LD_LH:   res = {{48{data[15]}}, data[15:0]};
            LD_LW:   res = {{32{data[31]}}, data[31:0]};
            LD_LBU:  res = {56'b0, data[7:0]};
            LD_LHU:  res = {48'b0, data[15:0]};
            LD_LWU:  res = {32'b0, data[31:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Per-channel result FIFO. Pointers carry one extra wrap bit so
//            full/empty are distinguished without a separate counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_entry_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_flush,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;
    T              r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign o_head    = r_mem[r_rptr[c_AW-1:0]];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // Pointer update; flush empties the FIFO regardless of push/pop
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/wb_merge_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_merge_unit
// Brief    : Merges NUM_CH buffered result channels into NUM_WP register-file
//            write ports with round-robin arbitration, same-destination
//            deferral and load-data formatting.
//            Optional macro WB_BYPASS_EN: an empty channel that wins
//            arbitration is written directly from its inputs (1-cycle path).
// Revision : 1.0 - initial release
// ============================================================================
module wb_merge_unit
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 4,
    parameter int NUM_WP = 1,
    parameter int DEPTH  = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [NUM_CH-1:0]              ch_valid_i,
    output logic [NUM_CH-1:0]              ch_ready_o,
    input  logic [NUM_CH-1:0][4:0]         ch_rd_i,
    input  logic [NUM_CH-1:0]              ch_fpr_i,
    input  logic [NUM_CH-1:0][2:0]         ch_fmt_i,
    input  logic [NUM_CH-1:0][XLEN-1:0]    ch_data_i,
    output logic [NUM_WP-1:0]              wp_rd_web_o,
    output logic [NUM_WP-1:0]              wp_frd_web_o,
    output logic [NUM_WP-1:0][4:0]         wp_rd_o,
    output logic [NUM_WP-1:0][XLEN-1:0]    wp_data_o,
    output logic                           busy_o
);

    localparam int c_CW = $clog2(NUM_CH);

    wb_entry_t         w_in_entry [NUM_CH];
    wb_entry_t         w_head     [NUM_CH];
    wb_entry_t         w_cand     [NUM_CH];
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_take;
    logic [NUM_CH-1:0] w_cand_vld;
    logic [NUM_CH-1:0] w_grant;

    logic [c_CW-1:0]   r_rr;
    logic [c_CW-1:0]   w_idx;
    logic [c_CW-1:0]   w_last;
    logic              w_any;
    logic              w_hz;
    int                w_ngnt;
    int                w_np;
    logic [4:0]        w_g_rd     [NUM_WP];
    logic              w_g_fpr    [NUM_WP];
    logic              w_port_vld [NUM_WP];
    logic [c_CW-1:0]   w_port_ch  [NUM_WP];
    wb_entry_t         w_port_ent [NUM_WP];
    logic [XLEN-1:0]   w_port_data[NUM_WP];

    logic [NUM_WP-1:0]           r_vld;
    logic [NUM_WP-1:0]           r_fpr;
    logic [NUM_WP-1:0][4:0]      r_rd;
    logic [NUM_WP-1:0][XLEN-1:0] r_data;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_in_entry[i].rd   = ch_rd_i[i];
            assign w_in_entry[i].fpr  = ch_fpr_i[i];
            assign w_in_entry[i].fmt  = ld_fmt_e'(ch_fmt_i[i]);
            assign w_in_entry[i].data = 64'(ch_data_i[i]);

`ifdef WB_BYPASS_EN
            assign w_cand_vld[i] = ~w_empty[i] | (ch_valid_i[i] & ~flush_i);
            assign w_cand[i]     = w_empty[i] ? w_in_entry[i] : w_head[i];
            assign w_take[i]     = w_grant[i] & w_empty[i];
`else
            assign w_cand_vld[i] = ~w_empty[i];
            assign w_cand[i]     = w_head[i];
            assign w_take[i]     = 1'b0;
`endif
            // A bypassed result never enters the FIFO
            assign w_push[i] = ch_valid_i[i] & ~w_full[i] & ~flush_i & ~w_take[i];
            assign w_pop[i]  = w_grant[i] & ~w_empty[i];

            wb_fifo #(
                .DEPTH (DEPTH),
                .T     (wb_entry_t)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .i_flush (flush_i),
                .i_push  (w_push[i]),
                .i_data  (w_in_entry[i]),
                .i_pop   (w_pop[i]),
                .o_head  (w_head[i]),
                .o_full  (w_full[i]),
                .o_empty (w_empty[i])
            );
        end
    endgenerate

    assign ch_ready_o = ~w_full;
    assign busy_o     = (|(~w_empty)) | (|r_vld);

    // Round-robin scan from r_rr; skip a candidate whose destination matches
    // one already granted this cycle, so it is retried later rather than lost
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_last  = r_rr;
        w_ngnt  = 0;
        w_idx   = '0;
        w_hz    = 1'b0;
        for (int p = 0; p < NUM_WP; p++) begin
            w_g_rd[p]  = '0;
            w_g_fpr[p] = 1'b0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = c_CW'((int'(r_rr) + k) % NUM_CH);
            w_hz  = 1'b0;
            for (int p = 0; p < NUM_WP; p++) begin
                if ((p < w_ngnt) && (w_g_rd[p] == w_cand[w_idx].rd) &&
                    (w_g_fpr[p] == w_cand[w_idx].fpr)) begin
                    w_hz = 1'b1;
                end
            end
            if (w_cand_vld[w_idx] && !w_hz && (w_ngnt < NUM_WP)) begin
                for (int p = 0; p < NUM_WP; p++) begin
                    if (p == w_ngnt) begin
                        w_g_rd[p]  = w_cand[w_idx].rd;
                        w_g_fpr[p] = w_cand[w_idx].fpr;
                    end
                end
                w_grant[w_idx] = 1'b1;
                w_last         = w_idx;
                w_any          = 1'b1;
                w_ngnt         = w_ngnt + 1;
            end
        end
    end

    // Map granted channels onto ports by ascending channel index and format
    always_comb begin
        w_np = 0;
        for (int p = 0; p < NUM_WP; p++) begin
            w_port_vld[p] = 1'b0;
            w_port_ch[p]  = '0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                for (int p = 0; p < NUM_WP; p++) begin
                    if (p == w_np) begin
                        w_port_vld[p] = 1'b1;
                        w_port_ch[p]  = c_CW'(i);
                    end
                end
                w_np = w_np + 1;
            end
        end
        for (int p = 0; p < NUM_WP; p++) begin
            w_port_ent[p]  = w_cand[w_port_ch[p]];
            w_port_data[p] = XLEN'(ld_format(w_port_ent[p].fmt,
                                             w_port_ent[p].data, XLEN == 64));
        end
    end

    // Output register: one-cycle write pulse per grant, zeros when idle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_vld  <= '0;
            r_fpr  <= '0;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            for (int p = 0; p < NUM_WP; p++) begin
                if (w_port_vld[p] && !flush_i) begin
                    r_vld[p]  <= 1'b1;
                    r_fpr[p]  <= w_port_ent[p].fpr;
                    r_rd[p]   <= w_port_ent[p].rd;
                    r_data[p] <= w_port_data[p];
                end else begin
                    r_vld[p]  <= 1'b0;
                    r_fpr[p]  <= 1'b0;
                    r_rd[p]   <= '0;
                    r_data[p] <= '0;
                end
            end
        end
    end

    // Round-robin pointer advances past the last grant; held across flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rr <= '0;
        end else if (w_any && !flush_i) begin
            r_rr <= (w_last == c_CW'(NUM_CH - 1)) ? '0 : w_last + 1'b1;
        end
    end

    assign wp_rd_web_o  = r_vld & ~r_fpr & {NUM_WP{1'b1}} &
                          {NUM_WP{1'b1}} & w_rd_nz();
    assign wp_frd_web_o = r_vld & r_fpr;
    assign wp_rd_o      = r_rd;
    assign wp_data_o    = r_data;

    // Per-port "destination is not x0" vector
    function automatic logic [NUM_WP-1:0] w_rd_nz();
        logic [NUM_WP-1:0] v;
        for (int p = 0; p < NUM_WP; p++) begin
            v[p] = (r_rd[p] != 5'd0);
        end
        return v;
    endfunction

endmodule
`default_nettype wire

// File: tb/tb_wb_merge_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_merge_unit
// Brief    : Directed bench for wb_merge_unit; one single-port and one
//            dual-port instance share the same channel inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_merge_unit;

`ifdef WB_BYPASS_EN
    localparam int c_LAT = 1;
`else
    localparam int c_LAT = 2;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [3:0]      vld_i = '0;
    logic [3:0][4:0] rd_i = '0;
    logic [3:0]      fpr_i = '0;
    logic [3:0][2:0] fmt_i = '0;
    logic [3:0][31:0] dat_i = '0;

    logic [3:0]       rdy1, rdy2;
    logic [0:0]       web1, fweb1;
    logic [0:0][4:0]  wrd1;
    logic [0:0][31:0] wdat1;
    logic             busy1;
    logic [1:0]       web2, fweb2;
    logic [1:0][4:0]  wrd2;
    logic [1:0][31:0] wdat2;
    logic             busy2;

    int n_vec = 0;
    int n_err = 0;
    int n7    = 0;
    int nwr   = 0;
    int dead  = 0;
    int acc   = 0;
    logic mon_en = 1'b0;
    logic low;

    always #5 clk_i = ~clk_i;

    wb_merge_unit #(.XLEN(32), .NUM_CH(4), .NUM_WP(1), .DEPTH(4)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .ch_valid_i(vld_i), .ch_ready_o(rdy1), .ch_rd_i(rd_i),
        .ch_fpr_i(fpr_i), .ch_fmt_i(fmt_i), .ch_data_i(dat_i),
        .wp_rd_web_o(web1), .wp_frd_web_o(fweb1), .wp_rd_o(wrd1),
        .wp_data_o(wdat1), .busy_o(busy1)
    );

    wb_merge_unit #(.XLEN(32), .NUM_CH(4), .NUM_WP(2), .DEPTH(4)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .ch_valid_i(vld_i), .ch_ready_o(rdy2), .ch_rd_i(rd_i),
        .ch_fpr_i(fpr_i), .ch_fmt_i(fmt_i), .ch_data_i(dat_i),
        .wp_rd_web_o(web2), .wp_frd_web_o(fweb2), .wp_rd_o(wrd2),
        .wp_data_o(wdat2), .busy_o(busy2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample outputs 1ns after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (web1[0] | fweb1[0] | (|web2) | (|fweb2)) nwr++;
        if (mon_en && web1[0] && wrd1[0] == 5'd7) begin
            n7++;
            if (wdat1[0] == 32'hDEAD) dead++;
        end
    endtask

    task automatic clr_in();
        vld_i = '0; rd_i = '0; fpr_i = '0; fmt_i = '0; dat_i = '0;
    endtask

    task automatic push(input int ch, input logic [4:0] rd, input logic fpr,
                        input logic [2:0] fmt, input logic [31:0] d);
        vld_i[ch] = 1'b1; rd_i[ch] = rd; fpr_i[ch] = fpr;
        fmt_i[ch] = fmt;  dat_i[ch] = d;
    endtask

    task automatic do_reset();
        clr_in();
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (!busy1 && !busy2) break;
            tick();
        end
        check("drain_idle", {busy1, busy2}, 2'b00);
    endtask

    // Push one vector on ch1 and check the formatted result
    task automatic fmt_vec(input string tag, input logic [2:0] fmt,
                           input logic [31:0] d, input logic [31:0] exp);
        push(1, 5'd10, 1'b0, fmt, d);
        tick();
        clr_in();
        repeat (c_LAT - 1) tick();
        check({tag, "_web"}, web1, 1'b1);
        check(tag, wdat1[0], exp);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_web", web1, 1'b0);
        check("rst_busy", {busy1, busy2}, 2'b00);
        check("rst_data", wdat1[0], 32'h0);
        #2;
        rst_i = 1'b1;
        tick();
        check("rst_ready", rdy1, 4'hF);

        // Dual-port hazard: ch0 and ch2 both target x5
        do_reset();
        push(0, 5'd5, 1'b0, 3'd0, 32'hA0);
        push(2, 5'd5, 1'b0, 3'd0, 32'hA2);
        tick();
        clr_in();
        repeat (c_LAT - 1) tick();
        check("hz_web_a", web2, 2'b01);
        check("hz_data_a", wdat2[0], 32'hA0);
        tick();
        check("hz_web_b", web2, 2'b01);
        check("hz_data_b", wdat2[0], 32'hA2);
        drain();

        // Same index, different files: both write together
        do_reset();
        push(0, 5'd5, 1'b0, 3'd0, 32'hA0);
        push(2, 5'd5, 1'b1, 3'd0, 32'hA2);
        tick();
        clr_in();
        repeat (c_LAT - 1) tick();
        check("nohz_web", web2, 2'b01);
        check("nohz_fweb", fweb2, 2'b10);
        check("nohz_rd1", wrd2[1], 5'd5);
        check("nohz_data1", wdat2[1], 32'hA2);
        drain();

        // Single port, four channels at once: ch0..ch3 in order
        do_reset();
        for (int c = 0; c < 4; c++) push(c, 5'(c + 1), 1'b0, 3'd0, 32'h100 + c);
        tick();
        clr_in();
        repeat (c_LAT - 1) tick();
        for (int c = 0; c < 4; c++) begin
            if (c != 0) tick();
            check("order_rd", wrd1[0], 5'(c + 1));
            check("order_data", wdat1[0], 32'h100 + c);
        end
        drain();
        push(3, 5'd4, 1'b0, 3'd0, 32'h3);
        push(0, 5'd1, 1'b0, 3'd0, 32'h0);
        tick();
        clr_in();
        repeat (c_LAT - 1) tick();
        check("rr_first", wrd1[0], 5'd1);
        tick();
        check("rr_second", wrd1[0], 5'd4);
        drain();

        // Load formatting
        fmt_vec("fmt_lb",  3'd1, 32'h000000F0, 32'hFFFFFFF0);
        fmt_vec("fmt_lhu", 3'd5, 32'hFFFF8001, 32'h00008001);
        fmt_vec("fmt_lh",  3'd2, 32'h00008000, 32'hFFFF8000);
        fmt_vec("fmt_lbu", 3'd4, 32'hFFFFFF80, 32'h00000080);
        fmt_vec("fmt_lwu", 3'd6, 32'hDEADBEEF, 32'hDEADBEEF);

        // Fill ch0 while all channels compete for the single port
        do_reset();
        mon_en = 1'b1;
        n7 = 0; acc = 0; dead = 0; low = 1'b0;
        for (int k = 0; k < 40 && !low; k++) begin
            push(0, 5'd7, 1'b0, 3'd0, 32'h200 + acc);
            push(1, 5'd8, 1'b0, 3'd0, 32'h1);
            push(2, 5'd9, 1'b0, 3'd0, 32'h2);
            push(3, 5'd10, 1'b0, 3'd0, 32'h3);
            if (rdy1[0]) acc++;
            tick();
            low = !rdy1[0];
        end
        check("full_rdy0", rdy1[0], 1'b0);
        clr_in();
        push(0, 5'd7, 1'b0, 3'd0, 32'hDEAD);
        tick();
        clr_in();
        for (int k = 0; k < 8; k++) begin
            if (rdy1[0]) break;
            tick();
        end
        check("rdy0_back", rdy1[0], 1'b1);
        drain();
        mon_en = 1'b0;
        check("ch0_count", n7, acc);
        check("blocked_push", dead, 0);

        // x0 is consumed without a write; f0 is writable
        push(0, 5'd0, 1'b0, 3'd0, 32'h55);
        tick();
        clr_in();
        repeat (c_LAT - 1) tick();
        check("x0_web", web1, 1'b0);
        check("x0_fweb", fweb1, 1'b0);
        check("x0_data", wdat1[0], 32'h55);
        drain();
        push(0, 5'd0, 1'b1, 3'd0, 32'h66);
        tick();
        clr_in();
        repeat (c_LAT - 1) tick();
        check("f0_fweb", fweb1, 1'b1);
        drain();

        // Flush with buffered entries and a push in the flush cycle
        do_reset();
        push(0, 5'd1, 1'b0, 3'd0, 32'h1);
        push(1, 5'd2, 1'b0, 3'd0, 32'h2);
        tick();
        clr_in();
        check("pre_flush_busy", busy1, 1'b1);
        flush_i = 1'b1;
        push(2, 5'd3, 1'b0, 3'd0, 32'h3);
        tick();
        flush_i = 1'b0;
        clr_in();
        check("flush_busy", {busy1, busy2}, 2'b00);
        check("flush_web", web1, 1'b0);
        nwr = 0;
        repeat (5) tick();
        check("flush_nowr", nwr, 0);

        // Asynchronous reset with three entries buffered
        do_reset();
        push(0, 5'd1, 1'b0, 3'd0, 32'h1);
        push(1, 5'd2, 1'b0, 3'd0, 32'h2);
        push(2, 5'd3, 1'b0, 3'd0, 32'h3);
        tick();
        clr_in();
        rst_i = 1'b0;
        #1;
        check("arst_web", {web1, web2, fweb1, fweb2}, 6'b0);
        check("arst_data", wdat1[0], 32'h0);
        check("arst_busy", {busy1, busy2}, 2'b00);
        #2;
        rst_i = 1'b1;
        nwr = 0;
        tick();
        check("arst_ready", {rdy1, rdy2}, 8'hFF);
        repeat (5) tick();
        check("arst_nowr", nwr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_merge_unit.md
Name: wb_merge_unit

Overview:
Parametrised successor of the single-path writeback stage. Merges NUM_CH independent result channels (ALU, GLSU, FPU, CSR, VPU scalar returns) into NUM_WP register-file write ports. Each channel has a per-channel FIFO with valid/ready handshake, load-data formatting is generalised to XLEN, and selection uses round-robin arbitration with same-destination hazard deferral. Sits between the MEM/FU completion buses and the integer/FP register files.

Parameters:
XLEN, 32, data width (32 or 64)
NUM_CH, 4, number of result channels (2..8)
NUM_WP, 1, register-file write ports (1 or 2)
DEPTH, 4, entries per channel FIFO (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
flush_i  in  1  trap/flush; discards all buffered results
ch_valid_i  in  NUM_CH  channel result valid
ch_ready_o  out  NUM_CH  channel FIFO not full
ch_rd_i  in  NUM_CH x 5  destination register
ch_fpr_i  in  NUM_CH  1 = FP register file
ch_fmt_i  in  NUM_CH x 3  ld_fmt_e: NONE/LB/LH/LW/LBU/LHU/LWU/LD
ch_data_i  in  NUM_CH x XLEN  raw result
wp_rd_web_o  out  NUM_WP  integer RF write enable
wp_frd_web_o  out  NUM_WP  FP RF write enable
wp_rd_o  out  NUM_WP x 5  write address
wp_data_o  out  NUM_WP x XLEN  formatted write data
busy_o  out  1  any FIFO non-empty or any output valid

Behaviour:
- Reset (rst_i low, async): FIFOs empty, rr pointer 0, all wp_* outputs 0, busy_o 0, ch_ready_o all 1 once released.
- Push when ch_valid_i & ch_ready_o; ch_ready_o = !full, from registered count (no same-cycle pop credit).
- Arbiter scans non-empty FIFO heads from rr_q upward (modulo NUM_CH), grants up to NUM_WP channels; max one pop per channel per cycle, so per-channel order is preserved.
- Hazard: a candidate with same rd and same file as an already-granted entry this cycle is skipped (deferred, not dropped).
- rr_q <= (last granted index + 1) mod NUM_CH; unchanged if no grant.
- Granted entries are formatted and registered into port order (lowest granted index -> port 0). Latency: push at t -> write at t+2 minimum.
- Formatting: LB/LH/LW sign-extend bits 7/15/31 to XLEN; LBU/LHU/LWU zero-extend; LD/NONE pass through; LWU/LD illegal when XLEN=32 (treated as NONE).
- wp_rd_web_o = valid & rd!=0 & !fpr; wp_frd_web_o = valid & fpr (f0 writable). Integer x0 entry is popped, nothing written.
- Outputs are valid one cycle per grant; no back-pressure from the register file.
- flush_i: at the next edge all FIFOs empty and all output valids clear; a push in the flush cycle is discarded; rr_q kept.
- FIFO wrap: pointers are log2(DEPTH)+1 bits; full = MSBs differ, low bits equal.

Optional Feature:
WB_BYPASS_EN: when defined, a channel whose FIFO is empty and which would win arbitration is written straight from ch_*_i into the output register. Latency becomes 1 cycle and the FIFO is not touched. Hazard, flush and port-order rules are unchanged. Without the macro, every result passes through the FIFO (latency 2).

Decomposition:
- Package wb_pkg holds ld_fmt_e, wb_entry_t {rd, fpr, fmt, data} and the ld_format function.
- Sub-module wb_fifo (DEPTH, entry type) with push/pop/full/empty/flush; one instance per channel.
- Arbiter and formatting stay in the top module.

Test Plan:
- Reset mid-burst: assert rst_i low while 3 entries buffered -> outputs 0 immediately; after release ch_ready_o = all 1 and no write occurs.
- NUM_WP=1, channels 0..3 each push 1 entry in the same cycle -> writes appear in order ch0, ch1, ch2, ch3 on cycles t+2..t+5; next rr start is ch0.
- Channel 1, fmt LB, data 0x000000F0 -> wp_data_o = 0xFFFFFFF0; fmt LHU, data 0xFFFF8001 -> 0x00008001.
- NUM_WP=2: ch0 and ch2 both target x5 (int) -> ch0 writes first, ch2 writes the next cycle; ch2 targeting f5 instead -> both write in the same cycle.
- Fill ch0 with DEPTH entries -> ch_ready_o[0]=0; push attempt ignored; one pop -> ready reasserts the following cycle; entry rd=x0 -> wp_rd_web_o stays 0.
- flush_i with 2 entries buffered plus a simultaneous push -> no writes follow, busy_o=0 next cycle; with WB_BYPASS_EN, an empty-FIFO push appears at t+1.
